// File: rtl/cursor_ctrl_if.sv
// Operation/elimination handshake bundle between key decoder, cursor_ctrl and board logic.
interface cursor_ctrl_if #(parameter int COORD_W = 4);
  logic               op_valid;
  logic [2:0]         op;
  logic               op_ready;
  logic               elim_done;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               selected;
  logic               elim_req;
  logic               busy;
  logic               op_ignored;

  modport master (
    output op_valid, op, elim_done,
    input  op_ready, cur_x, cur_y, selected, elim_req, busy, op_ignored
  );

  modport slave (
    input  op_valid, op, elim_done,
    output op_ready, cur_x, cur_y, selected, elim_req, busy, op_ignored
  );
endinterface

// File: rtl/cursor_ctrl.sv
// Cursor/selection controller for the grid elimination game.
// Define CURSOR_WRAP_EN to make cursor moves wrap at the grid edges instead of saturating.
module cursor_ctrl #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int COORD_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  cursor_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEL, ELIM} state_t;

  localparam logic [2:0] OP_NOP = 3'd0, OP_SEL = 3'd1, OP_CAN = 3'd2, OP_LEFT = 3'd3,
                         OP_RIGHT = 3'd4, OP_UP = 3'd5, OP_DOWN = 3'd6, OP_HOME = 3'd7;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] ZERO  = '0;
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  state_t state;

`ifdef CURSOR_WRAP_EN
  localparam logic [COORD_W-1:0] X_LO = X_MAX, X_HI = ZERO, Y_LO = Y_MAX, Y_HI = ZERO;
`else
  localparam logic [COORD_W-1:0] X_LO = ZERO, X_HI = X_MAX, Y_LO = ZERO, Y_HI = Y_MAX;
`endif

  // Edge targets: wrap jumps to the opposite edge, saturation stays put.
  logic [COORD_W-1:0] x_left, x_right, y_up, y_down;
  always_comb begin
    x_left  = (bus.cur_x == ZERO)  ? X_LO : bus.cur_x - ONE;
    x_right = (bus.cur_x == X_MAX) ? X_HI : bus.cur_x + ONE;
    y_up    = (bus.cur_y == ZERO)  ? Y_LO : bus.cur_y - ONE;
    y_down  = (bus.cur_y == Y_MAX) ? Y_HI : bus.cur_y + ONE;
  end

  assign bus.op_ready = (state != ELIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.cur_x      <= '0;
      bus.cur_y      <= '0;
      bus.selected   <= 1'b0;
      bus.elim_req   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.op_ignored <= 1'b0;
    end else begin
      bus.op_ignored <= 1'b0;
      case (state)
        IDLE: if (bus.op_valid) begin
          case (bus.op)
            OP_SEL:   begin state <= SEL; bus.selected <= 1'b1; end
            OP_CAN:   bus.op_ignored <= 1'b1;
            OP_LEFT:  bus.cur_x <= x_left;
            OP_RIGHT: bus.cur_x <= x_right;
            OP_UP:    bus.cur_y <= y_up;
            OP_DOWN:  bus.cur_y <= y_down;
            OP_HOME:  begin bus.cur_x <= '0; bus.cur_y <= '0; end
            default:  ;
          endcase
        end
        SEL: if (bus.op_valid) begin
          case (bus.op)
            OP_NOP:  ;
            OP_SEL:  begin state <= ELIM; bus.elim_req <= 1'b1; bus.busy <= 1'b1; end
            OP_CAN:  begin state <= IDLE; bus.selected <= 1'b0; end
            default: bus.op_ignored <= 1'b1;  // cursor frozen while a cell is selected
          endcase
        end
        ELIM: if (bus.elim_done) begin
          // op_ready is low here, so any op presented this cycle waits for IDLE.
          state        <= IDLE;
          bus.selected <= 1'b0;
          bus.elim_req <= 1'b0;
          bus.busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
